// File: rtl/wb_commit.sv
// Writeback/commit stage: a small in-order queue of completed instructions whose
// head is presented on the register/segment write ports, one instruction per cycle.
module wb_commit #(
    parameter int DEPTH    = 2,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                valid_in,
    input  logic [63:0]         res_data1,
    input  logic [63:0]         res_data2,
    input  logic [63:0]         res_data3,
    input  logic [63:0]         res_data4,
    input  logic [2:0]          res_addr1,
    input  logic [2:0]          res_addr2,
    input  logic [2:0]          res_addr3,
    input  logic [2:0]          res_addr4,
    input  logic [15:0]         res_segdata1,
    input  logic [15:0]         res_segdata2,
    input  logic [15:0]         res_segdata3,
    input  logic [15:0]         res_segdata4,
    input  logic [2:0]          res_segaddr1,
    input  logic [2:0]          res_segaddr2,
    input  logic [2:0]          res_segaddr3,
    input  logic [2:0]          res_segaddr4,
    input  logic [3:0]          res_regld,
    input  logic [3:0]          res_segld,
    input  logic [1:0]          res_opsize,
    input  logic [6:0]          res_ptcid,
    input  logic                drain_hold,
    input  logic                flush,
    output logic                stall,
    output logic [63:0]         wb_data1,
    output logic [63:0]         wb_data2,
    output logic [63:0]         wb_data3,
    output logic [63:0]         wb_data4,
    output logic [2:0]          wb_addr1,
    output logic [2:0]          wb_addr2,
    output logic [2:0]          wb_addr3,
    output logic [2:0]          wb_addr4,
    output logic [15:0]         wb_segdata1,
    output logic [15:0]         wb_segdata2,
    output logic [15:0]         wb_segdata3,
    output logic [15:0]         wb_segdata4,
    output logic [2:0]          wb_segaddr1,
    output logic [2:0]          wb_segaddr2,
    output logic [2:0]          wb_segaddr3,
    output logic [2:0]          wb_segaddr4,
    output logic [1:0]          wb_opsize,
    output logic [3:0]          wb_regld,
    output logic [3:0]          wb_segld,
    output logic [6:0]          wb_inst_ptcid,
    output logic                retire_valid,
    output logic [RETIRE_W-1:0] retire_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [255:0] q_data    [DEPTH];
    logic [11:0]  q_addr    [DEPTH];
    logic [63:0]  q_segdata [DEPTH];
    logic [11:0]  q_segaddr [DEPTH];
    logic [3:0]   q_regld   [DEPTH];
    logic [3:0]   q_segld   [DEPTH];
    logic [1:0]   q_opsize  [DEPTH];
    logic [6:0]   q_ptcid   [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic             enq, ret;
    logic [255:0]     head_data;
    logic [11:0]      head_addr;
    logic [63:0]      head_segdata;
    logic [11:0]      head_segaddr;

    // Lower-indexed slots lose to any later enabled slot writing the same register.
    function automatic logic [3:0] resolve_conflicts(input logic [3:0] en, input logic [11:0] addr);
        logic [3:0] keep;
        keep = en;
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (en[i] && en[j] && (addr[i*3 +: 3] == addr[j*3 +: 3]))
                    keep[i] = 1'b0;
            end
        end
        return keep;
    endfunction

    // stall looks only at registered occupancy, never at same-cycle retirement.
    assign stall        = (count == CNT_W'(DEPTH));
    assign ret          = (count != '0) && !drain_hold && !flush && !clr;
    assign enq          = valid_in && !stall && !flush && !clr;
    assign retire_valid = ret;

    always_ff @(posedge clk) begin
        if (clr) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            retire_count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)
                tail <= tail + PTR_W'(1);
            if (ret) begin
                head         <= head + PTR_W'(1);
                retire_count <= retire_count + RETIRE_W'(1);
            end
            case ({enq, ret})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_data[tail]    <= {res_data4, res_data3, res_data2, res_data1};
            q_addr[tail]    <= {res_addr4, res_addr3, res_addr2, res_addr1};
            q_segdata[tail] <= {res_segdata4, res_segdata3, res_segdata2, res_segdata1};
            q_segaddr[tail] <= {res_segaddr4, res_segaddr3, res_segaddr2, res_segaddr1};
            q_regld[tail]   <= res_regld;
            q_segld[tail]   <= res_segld;
            q_opsize[tail]  <= res_opsize;
            q_ptcid[tail]   <= res_ptcid;
        end
    end

    // Outputs are forced to zero whenever no write is being issued.
    assign head_data     = ret ? q_data[head]    : '0;
    assign head_addr     = ret ? q_addr[head]    : '0;
    assign head_segdata  = ret ? q_segdata[head] : '0;
    assign head_segaddr  = ret ? q_segaddr[head] : '0;
    assign wb_opsize     = ret ? q_opsize[head]  : '0;
    assign wb_inst_ptcid = ret ? q_ptcid[head]   : '0;
    assign wb_regld      = ret ? resolve_conflicts(q_regld[head], q_addr[head])    : '0;
    assign wb_segld      = ret ? resolve_conflicts(q_segld[head], q_segaddr[head]) : '0;

    assign wb_data1    = head_data[63:0];
    assign wb_data2    = head_data[127:64];
    assign wb_data3    = head_data[191:128];
    assign wb_data4    = head_data[255:192];
    assign wb_addr1    = head_addr[2:0];
    assign wb_addr2    = head_addr[5:3];
    assign wb_addr3    = head_addr[8:6];
    assign wb_addr4    = head_addr[11:9];
    assign wb_segdata1 = head_segdata[15:0];
    assign wb_segdata2 = head_segdata[31:16];
    assign wb_segdata3 = head_segdata[47:32];
    assign wb_segdata4 = head_segdata[63:48];
    assign wb_segaddr1 = head_segaddr[2:0];
    assign wb_segaddr2 = head_segaddr[5:3];
    assign wb_segaddr3 = head_segaddr[8:6];
    assign wb_segaddr4 = head_segaddr[11:9];

endmodule

// File: tb/tb_wb_commit.sv
// Scoreboard bench for wb_commit: accepted instructions queue up as expected
// writes; a monitor compares each presented write against the queue head.
module tb_wb_commit;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [255:0] data;
        logic [11:0]  addr;
        logic [63:0]  segdata;
        logic [11:0]  segaddr;
        logic [3:0]   regld;
        logic [3:0]   segld;
        logic [1:0]   opsize;
        logic [6:0]   ptcid;
    } inst_t;

    logic clk, clr, valid_in, drain_hold, flush;
    inst_t cur;

    logic        stall, retire_valid;
    logic [63:0] wb_data1, wb_data2, wb_data3, wb_data4;
    logic [2:0]  wb_addr1, wb_addr2, wb_addr3, wb_addr4;
    logic [15:0] wb_segdata1, wb_segdata2, wb_segdata3, wb_segdata4;
    logic [2:0]  wb_segaddr1, wb_segaddr2, wb_segaddr3, wb_segaddr4;
    logic [1:0]  wb_opsize;
    logic [3:0]  wb_regld, wb_segld;
    logic [6:0]  wb_inst_ptcid;
    logic [31:0] retire_count;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic final_req = 1'b0;

    wb_commit #(.DEPTH(DEPTH), .RETIRE_W(32)) dut (
        .clk(clk), .clr(clr), .valid_in(valid_in),
        .res_data1(cur.data[63:0]), .res_data2(cur.data[127:64]),
        .res_data3(cur.data[191:128]), .res_data4(cur.data[255:192]),
        .res_addr1(cur.addr[2:0]), .res_addr2(cur.addr[5:3]),
        .res_addr3(cur.addr[8:6]), .res_addr4(cur.addr[11:9]),
        .res_segdata1(cur.segdata[15:0]), .res_segdata2(cur.segdata[31:16]),
        .res_segdata3(cur.segdata[47:32]), .res_segdata4(cur.segdata[63:48]),
        .res_segaddr1(cur.segaddr[2:0]), .res_segaddr2(cur.segaddr[5:3]),
        .res_segaddr3(cur.segaddr[8:6]), .res_segaddr4(cur.segaddr[11:9]),
        .res_regld(cur.regld), .res_segld(cur.segld),
        .res_opsize(cur.opsize), .res_ptcid(cur.ptcid),
        .drain_hold(drain_hold), .flush(flush), .stall(stall),
        .wb_data1(wb_data1), .wb_data2(wb_data2), .wb_data3(wb_data3), .wb_data4(wb_data4),
        .wb_addr1(wb_addr1), .wb_addr2(wb_addr2), .wb_addr3(wb_addr3), .wb_addr4(wb_addr4),
        .wb_segdata1(wb_segdata1), .wb_segdata2(wb_segdata2),
        .wb_segdata3(wb_segdata3), .wb_segdata4(wb_segdata4),
        .wb_segaddr1(wb_segaddr1), .wb_segaddr2(wb_segaddr2),
        .wb_segaddr3(wb_segaddr3), .wb_segaddr4(wb_segaddr4),
        .wb_opsize(wb_opsize), .wb_regld(wb_regld), .wb_segld(wb_segld),
        .wb_inst_ptcid(wb_inst_ptcid), .retire_valid(retire_valid),
        .retire_count(retire_count)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Walk slots from highest to lowest; the first writer seen for an address owns it.
    function automatic logic [3:0] winners(input logic [3:0] en, input logic [11:0] addr);
        logic [7:0] claimed;
        logic [3:0] w;
        logic [2:0] a;
        claimed = '0;
        w = '0;
        for (int s = 3; s >= 0; s--) begin
            a = addr[s*3 +: 3];
            if (en[s] && !claimed[a]) begin
                w[s] = 1'b1;
                claimed[a] = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic inst_t rand_inst(input logic [6:0] id);
        inst_t t;
        for (int k = 0; k < 8; k++) t.data[k*32 +: 32] = $urandom;
        t.addr    = 12'($urandom);
        t.segdata = {$urandom, $urandom};
        t.segaddr = 12'($urandom);
        t.regld   = 4'($urandom);
        t.segld   = 4'($urandom);
        t.opsize  = 2'($urandom);
        t.ptcid   = id;
        return t;
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard and monitor: check at negedge, update the model at posedge.
    initial begin
        inst_t sb[$];
        inst_t e;
        logic [31:0] exp_rc;
        logic exp_ret, m_stall, just_reset, final_done, accept;
        exp_rc = '0;
        just_reset = 1'b0;
        final_done = 1'b0;
        m_stall = 1'b0;
        forever begin
            @(negedge clk);
            m_stall = (sb.size() == DEPTH);
            exp_ret = (sb.size() > 0) && !drain_hold && !flush && !clr;
            if (mon_en) begin
                check("stall", 256'(stall), 256'(m_stall));
                check("retire_valid", 256'(retire_valid), 256'(exp_ret));
                check("retire_count", 256'(retire_count), 256'(exp_rc));
                if (exp_ret) begin
                    e = sb.pop_front();
                    exp_rc++;
                    if (retire_valid) begin
                        check("wb_regld", 256'(wb_regld), 256'(winners(e.regld, e.addr)));
                        check("wb_segld", 256'(wb_segld), 256'(winners(e.segld, e.segaddr)));
                        check("wb_inst_ptcid", 256'(wb_inst_ptcid), 256'(e.ptcid));
                        check("wb_opsize", 256'(wb_opsize), 256'(e.opsize));
                        check("wb_data", {wb_data4, wb_data3, wb_data2, wb_data1}, e.data);
                        check("wb_addr", 256'({wb_addr4, wb_addr3, wb_addr2, wb_addr1}), 256'(e.addr));
                        check("wb_segdata", 256'({wb_segdata4, wb_segdata3, wb_segdata2, wb_segdata1}),
                              256'(e.segdata));
                        check("wb_segaddr", 256'({wb_segaddr4, wb_segaddr3, wb_segaddr2, wb_segaddr1}),
                              256'(e.segaddr));
                    end
                end else begin
                    check("idle_regld", 256'(wb_regld), 256'(0));
                    check("idle_segld", 256'(wb_segld), 256'(0));
                end
                if (just_reset) begin
                    check("reset_data", {wb_data4, wb_data3, wb_data2, wb_data1}, 256'(0));
                    check("reset_addr", 256'({wb_addr4, wb_addr3, wb_addr2, wb_addr1,
                          wb_segaddr4, wb_segaddr3, wb_segaddr2, wb_segaddr1}), 256'(0));
                    check("reset_segdata", 256'({wb_segdata4, wb_segdata3, wb_segdata2, wb_segdata1}),
                          256'(0));
                    just_reset = 1'b0;
                end
                if (final_req && !final_done) begin
                    check("queue_drained", 256'(sb.size()), 256'(0));
                    final_done = 1'b1;
                end
            end
            @(posedge clk);
            accept = valid_in && !m_stall && !flush && !clr;
            if (clr) begin
                sb.delete();
                exp_rc = '0;
                just_reset = 1'b1;
            end else if (flush) begin
                sb.delete();
            end else if (accept) begin
                sb.push_back(cur);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        inst_t t;
        logic acc;
        clr = 1'b1; valid_in = 1'b0; drain_hold = 1'b0; flush = 1'b0; cur = '0;
        cycle();
        clr = 1'b0;
        mon_en = 1'b1;
        cycle();

        // Single instruction, earliest retirement
        t = rand_inst(7'h15);
        t.regld = 4'b0001; t.segld = 4'b0000;
        t.addr[2:0] = 3'd3; t.data[63:0] = 64'hDEAD_BEEF;
        cur = t; valid_in = 1'b1;
        cycle();
        valid_in = 1'b0;
        repeat (3) cycle();

        // Fill under drain_hold, third offer ignored, then drain
        drain_hold = 1'b1;
        cur = rand_inst(7'h21); valid_in = 1'b1; cycle();
        cur = rand_inst(7'h22); cycle();
        cur = rand_inst(7'h23); cycle();
        valid_in = 1'b0; drain_hold = 1'b0;
        repeat (4) cycle();

        // Address conflicts inside one instruction
        t = rand_inst(7'h30);
        t.regld = 4'b1111; t.addr = {3'd2, 3'd2, 3'd5, 3'd2};
        t.segld = 4'b0011; t.segaddr[5:0] = {3'd1, 3'd1};
        cur = t; valid_in = 1'b1;
        cycle();
        valid_in = 1'b0;
        repeat (2) cycle();

        // Flush with a concurrent enqueue
        drain_hold = 1'b1;
        cur = rand_inst(7'h41); valid_in = 1'b1; cycle();
        cur = rand_inst(7'h42); cycle();
        cur = rand_inst(7'h43); flush = 1'b1; drain_hold = 1'b0; cycle();
        flush = 1'b0; valid_in = 1'b0;
        repeat (3) cycle();

        // Reset while full
        drain_hold = 1'b1;
        cur = rand_inst(7'h51); valid_in = 1'b1; cycle();
        cur = rand_inst(7'h52); cycle();
        valid_in = 1'b0; clr = 1'b1; drain_hold = 1'b0; cycle();
        clr = 1'b0;
        repeat (2) cycle();

        // Stream of 10 with drain_hold toggling; execute holds while stalled
        drain_hold = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cur = rand_inst(7'(8'h60 + k));
            valid_in = 1'b1;
            for (int n = 0; n < 20; n++) begin
                drain_hold = ~drain_hold;
                acc = !stall;
                cycle();
                if (acc) break;
            end
        end
        valid_in = 1'b0; drain_hold = 1'b0;
        repeat (4) cycle();

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            if (!(stall && valid_in)) cur = rand_inst(7'($urandom));
            valid_in   = ($urandom % 4) != 0;
            drain_hold = ($urandom % 3) == 0;
            flush      = ($urandom % 25) == 0;
            cycle();
        end
        valid_in = 1'b0; drain_hold = 1'b0; flush = 1'b0;
        repeat (4) cycle();
        final_req = 1'b1;
        repeat (2) cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
